dp_ram_be: RTL and testbench

Parametrised true dual-port RAM with byte-write enables and configurable read latency. It also selects read-during-write behaviour and performs a hardware initialisation sweep after reset. It replaces the single-port, reset-clears-everything memory in the design: every word is still restored to INIT after reset, but by a one-word-per-cycle sweep that maps onto block RAM. Two independent clients (ports A and B) share one storage array.

---
 rtl/dp_ram_pkg.sv | 38 +++
 rtl/dp_ram_rdpipe.sv | 58 +++++
 rtl/dp_ram_be.sv | 163 ++++++++++++++++
 tb/tb_dp_ram_be.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and the byte-lane merge helper for the dual-port RAM.
package dp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_e;

    // Widest word the merge helper handles; callers zero-extend into it and
    // truncate the result back to their own width.
    localparam int unsigned MERGE_W  = 512;
    localparam int unsigned MERGE_IW = $clog2(MERGE_W);

    // Returns old_w with every byte lane whose be bit is set replaced by d.
    // Lane i covers bits [i*bw +: bw]; be bits beyond the caller's lane count
    // are zero, so padding bits always keep old_w.
    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] d,
        input logic [MERGE_W-1:0] be,
        input int unsigned        bw
    );
        logic [MERGE_W-1:0] r;
        r = old_w;
        for (int unsigned b = 0; b < MERGE_W; b++) begin
            if (be[MERGE_IW'(b / bw)]) begin
                r[MERGE_IW'(b)] = d[MERGE_IW'(b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_ram_rdpipe.sv
// Read-data output pipeline for one RAM port: RL register stages that hold
// their contents whenever no read is issued, so q tracks the latest read.
module dp_ram_rdpipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned RL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    if (RL == 1) begin : g_rl1
        logic [DW-1:0] s1_q;

        // Single stage: capture the read word on every accepted access.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= '0;
            end else if (en_i) begin
                s1_q <= d_i;
            end
        end

        assign q_o = s1_q;
    end else begin : g_rl2
        logic [DW-1:0] s1_q;
        logic [DW-1:0] s2_q;
        logic          v1_q;

        // First stage captures the read word and flags it as fresh.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                v1_q <= en_i;
                if (en_i) begin
                    s1_q <= d_i;
                end
            end
        end

        // Second stage only moves on a fresh first-stage word, so an idle
        // port leaves q at the most recent enabled read.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_q <= '0;
            end else if (v1_q) begin
                s2_q <= s1_q;
            end
        end

        assign q_o = s2_q;
    end

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte enables, selectable read latency and
// read-during-write mode. After reset a one-word-per-cycle sweep writes INIT
// to every location; ports are ignored until the sweep finishes.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int unsigned   LEN  = 256,
    parameter int unsigned   DW   = 32,
    parameter int unsigned   BW   = 8,
    parameter int unsigned   RL   = 1,
    parameter bit            RDW  = 1'b0,
    parameter logic [DW-1:0] INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   busy,
    input  logic                   a_en,
    input  logic                   a_wr,
    input  logic [$clog2(LEN)-1:0] a_addr,
    input  logic [DW/BW-1:0]       a_be,
    input  logic [DW-1:0]          a_d,
    output logic [DW-1:0]          a_q,
    input  logic                   b_en,
    input  logic                   b_wr,
    input  logic [$clog2(LEN)-1:0] b_addr,
    input  logic [DW/BW-1:0]       b_be,
    input  logic [DW-1:0]          b_d,
    output logic [DW-1:0]          b_q
);

    localparam int unsigned AW       = $clog2(LEN);
    localparam logic [AW-1:0] LAST   = AW'(LEN - 1);
    localparam rdw_e        RDW_MODE = rdw_e'(RDW);

    logic [DW-1:0] mem_q [LEN];

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          run;
    logic          a_inr, b_inr;
    logic          a_acc, b_acc;
    logic          a_we, b_we;
    logic          same_addr;
    logic [DW-1:0] a_own, b_new, a_base, a_new;
    logic [DW-1:0] a_rd, b_rd;

    assign run  = (state_q == RUN);
    assign busy = ~run;

    // Address range checks matter only when LEN is not a power of two.
    assign a_inr = 32'(a_addr) < LEN;
    assign b_inr = 32'(b_addr) < LEN;

    assign a_acc = run & a_en;
    assign b_acc = run & b_en;
    assign a_we  = a_acc & a_wr & a_inr;
    assign b_we  = b_acc & b_wr & b_inr;

    assign same_addr = (a_addr == b_addr);

    // Each port's own merge onto the pre-write word. When both ports hit the
    // same word, A merges on top of B's result so A wins shared lanes while
    // B-only lanes survive.
    assign b_new  = DW'(be_merge(MERGE_W'(mem_q[b_addr]), MERGE_W'(b_d),
                                 MERGE_W'(b_be), BW));
    assign a_own  = DW'(be_merge(MERGE_W'(mem_q[a_addr]), MERGE_W'(a_d),
                                 MERGE_W'(a_be), BW));
    assign a_base = (b_we && same_addr) ? b_new : mem_q[a_addr];
    assign a_new  = DW'(be_merge(MERGE_W'(a_base), MERGE_W'(a_d),
                                 MERGE_W'(a_be), BW));

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep next state: step through every word, leave CLEAR after the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:     ;
            default: state_d = CLEAR;
        endcase
    end

    // Storage writes: sweep in CLEAR, port writes in RUN (A issued last so it
    // overrides B on a shared address; a_new already carries B's lanes).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= INIT;
            end else begin
                if (b_we) begin
                    mem_q[b_addr] <= b_new;
                end
                if (a_we) begin
                    mem_q[a_addr] <= a_new;
                end
            end
        end
    end

    // Port A read word. Write-first returns this port's own merge; the other
    // port's same-cycle write is never visible.
    always_comb begin
        a_rd = '0;
        if (a_inr) begin
            a_rd = mem_q[a_addr];
            if (RDW_MODE == WRITE_FIRST && a_wr) begin
                a_rd = a_own;
            end
        end
    end

    // Port B read word, same rules as port A.
    always_comb begin
        b_rd = '0;
        if (b_inr) begin
            b_rd = mem_q[b_addr];
            if (RDW_MODE == WRITE_FIRST && b_wr) begin
                b_rd = b_new;
            end
        end
    end

    dp_ram_rdpipe #(
        .DW (DW),
        .RL (RL)
    ) u_rdpipe_a (
        .clk  (clk),
        .rst  (rst),
        .en_i (a_acc),
        .d_i  (a_rd),
        .q_o  (a_q)
    );

    dp_ram_rdpipe #(
        .DW (DW),
        .RL (RL)
    ) u_rdpipe_b (
        .clk  (clk),
        .rst  (rst),
        .en_i (b_acc),
        .d_i  (b_rd),
        .q_o  (b_q)
    );

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (LEN=64/RL=1/read-first/INIT=0 and
// LEN=50/RL=2/write-first/nonzero INIT) share stimulus and are checked
// against a word-array reference model.
module tb_dp_ram_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [31:0] a_d = '0, b_d = '0;
    logic        bsy [2];
    logic [31:0] aq [2];
    logic [31:0] bq [2];

    int          len_c  [2] = '{64, 50};
    int          rl_c   [2] = '{1, 2};
    int          rdw_c  [2] = '{0, 1};
    logic [31:0] init_c [2] = '{32'h0000_0000, 32'h5A5A_A5A5};

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] mm [2][64];
    int          since [2] = '{0, 0};
    logic [31:0] last_a [2] = '{0, 0};
    logic [31:0] last_b [2] = '{0, 0};
    logic [31:0] lag_a  [2] = '{0, 0};
    logic [31:0] lag_b  [2] = '{0, 0};

    always #5 clk = ~clk;

    dp_ram_be #(.LEN(64), .DW(32), .BW(8), .RL(1), .RDW(1'b0), .INIT(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .busy(bsy[0]),
        .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_be(a_be), .a_d(a_d), .a_q(aq[0]),
        .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_be(b_be), .b_d(b_d), .b_q(bq[0])
    );

    dp_ram_be #(.LEN(50), .DW(32), .BW(8), .RL(2), .RDW(1'b1), .INIT(32'h5A5A_A5A5)) dut1 (
        .clk(clk), .rst(rst), .busy(bsy[1]),
        .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_be(a_be), .a_d(a_d), .a_q(aq[1]),
        .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_be(b_be), .b_d(b_d), .b_q(bq[1])
    );

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(int d, logic [5:0] addr, logic wr, logic [31:0] wd, logic [3:0] be);
        if (int'(addr) >= len_c[d]) return 32'h0;
        if (rdw_c[d] == 1 && wr) return merge(mm[d][addr], wd, be);
        return mm[d][addr];
    endfunction

    function automatic logic e_busy(int d);
        return since[d] < len_c[d];
    endfunction

    // q shows the most recent enabled read, RL-1 cycles late
    function automatic logic [31:0] e_aq(int d);
        return (rl_c[d] == 1) ? last_a[d] : lag_a[d];
    endfunction

    function automatic logic [31:0] e_bq(int d);
        return (rl_c[d] == 1) ? last_b[d] : lag_b[d];
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            lag_a[d] = last_a[d];
            lag_b[d] = last_b[d];
            if (rst) begin
                since[d]  = 0;
                last_a[d] = 0; last_b[d] = 0; lag_a[d] = 0; lag_b[d] = 0;
            end else if (since[d] < len_c[d]) begin
                mm[d][since[d]] = init_c[d];
                since[d]++;
            end else begin
                if (a_en) last_a[d] = ref_read(d, a_addr, a_wr, a_d, a_be);
                if (b_en) last_b[d] = ref_read(d, b_addr, b_wr, b_d, b_be);
                if (b_en && b_wr && int'(b_addr) < len_c[d]) mm[d][b_addr] = merge(mm[d][b_addr], b_d, b_be);
                if (a_en && a_wr && int'(a_addr) < len_c[d]) mm[d][a_addr] = merge(mm[d][a_addr], a_d, a_be);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_a(logic en, logic wr, logic [5:0] ad, logic [3:0] be, logic [31:0] d);
        a_en = en; a_wr = wr; a_addr = ad; a_be = be; a_d = d;
    endtask

    task automatic set_b(logic en, logic wr, logic [5:0] ad, logic [3:0] be, logic [31:0] d);
        b_en = en; b_wr = wr; b_addr = ad; b_be = be; b_d = d;
    endtask

    task automatic idle();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                n_cmp += 3;
                if (bsy[d] !== 1'b1) begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 1", d, bsy[d]); end
                if (aq[d] !== 32'h0) begin n_bad++; $display("FAIL reset_aq dut%0d got %h want 0", d, aq[d]); end
                if (bq[d] !== 32'h0) begin n_bad++; $display("FAIL reset_bq dut%0d got %h want 0", d, bq[d]); end
            end
        end
    endtask

    // Release reset, time the sweep, then read every address on both ports.
    task automatic test_init();
        int done_at [2] = '{0, 0};
        rst = 1'b0;
        for (int k = 1; k <= 200 && (done_at[0] == 0 || done_at[1] == 0); k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                if (!bsy[d] && done_at[d] == 0) done_at[d] = k;
                n_cmp += 3;
                if (bsy[d] !== e_busy(d)) begin n_bad++; $display("FAIL init_busy dut%0d got %b want %b", d, bsy[d], e_busy(d)); end
                if (aq[d] !== 32'h0) begin n_bad++; $display("FAIL init_aq dut%0d got %h want 0", d, aq[d]); end
                if (bq[d] !== 32'h0) begin n_bad++; $display("FAIL init_bq dut%0d got %h want 0", d, bq[d]); end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (done_at[d] != len_c[d]) begin n_bad++; $display("FAIL init_len dut%0d got %0d want %0d", d, done_at[d], len_c[d]); end
        end
        for (int a = 0; a < 66; a++) begin
            if (a < 64) begin
                set_a(1, 0, 6'(a), 0, 0);
                set_b(1, 0, 6'(63 - a), 0, 0);
            end else idle();
            cyc();
            for (int d = 0; d < 2; d++) begin
                n_cmp += 2;
                if (aq[d] !== e_aq(d)) begin n_bad++; $display("FAIL init_rd_a dut%0d a=%0d got %h want %h", d, a, aq[d], e_aq(d)); end
                if (bq[d] !== e_bq(d)) begin n_bad++; $display("FAIL init_rd_b dut%0d a=%0d got %h want %h", d, a, bq[d], e_bq(d)); end
            end
        end
    endtask

    task automatic test_byte_write();
        set_a(1, 1, 5, 4'hF, 32'h1122_3344); cyc();
        set_a(1, 1, 5, 4'b0101, 32'hAABB_CCDD); cyc();
        set_a(1, 0, 5, 4'h0, 32'h0); cyc();
        idle(); cyc(); cyc();
        for (int d = 0; d < 2; d++) begin
            n_cmp += 2;
            if (aq[d] !== 32'h11BB_33DD) begin n_bad++; $display("FAIL byte_write dut%0d got %h want 11bb33dd", d, aq[d]); end
            if (aq[d] !== e_aq(d)) begin n_bad++; $display("FAIL byte_write_model dut%0d got %h want %h", d, aq[d], e_aq(d)); end
        end
    endtask

    task automatic test_rdw();
        set_a(1, 1, 7, 4'hF, 32'h0); cyc();
        set_a(1, 1, 7, 4'hF, 32'h1234_5678);
        set_b(1, 0, 7, 4'h0, 32'h0); cyc();
        idle(); cyc(); cyc();
        n_cmp += 4;
        if (aq[0] !== 32'h0) begin n_bad++; $display("FAIL rdw_read_first got %h want 0", aq[0]); end
        if (aq[1] !== 32'h1234_5678) begin n_bad++; $display("FAIL rdw_write_first got %h want 12345678", aq[1]); end
        if (bq[0] !== 32'h0) begin n_bad++; $display("FAIL rdw_cross dut0 got %h want 0", bq[0]); end
        if (bq[1] !== 32'h0) begin n_bad++; $display("FAIL rdw_cross dut1 got %h want 0", bq[1]); end
    endtask

    task automatic test_collision();
        set_a(1, 1, 9, 4'hF, 32'h0); cyc();
        set_a(1, 1, 9, 4'b1100, 32'hAAAA_AAAA);
        set_b(1, 1, 9, 4'b0110, 32'hBBBB_BBBB); cyc();
        set_a(1, 0, 9, 0, 0); set_b(0, 0, 0, 0, 0); cyc();
        idle(); cyc(); cyc();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (aq[d] !== 32'hAAAA_BB00) begin n_bad++; $display("FAIL collision dut%0d got %h want aaaabb00", d, aq[d]); end
        end
    endtask

    // Exact per-cycle latency and hold behaviour of both pipeline depths.
    task automatic test_rl2();
        logic [31:0] want0 [7] = '{32'h10, 32'h20, 32'h30, 32'h30, 32'h30, 32'h30, 32'h30};
        logic [31:0] want1 [7] = '{32'h5A5A_A5A5, 32'h10, 32'h20, 32'h30, 32'h30, 32'h30, 32'h30};
        for (int i = 1; i <= 3; i++) begin
            set_a(1, 1, 6'(i), 4'hF, 32'(i * 16)); cyc();
        end
        set_a(1, 0, 0, 0, 0); cyc();
        idle(); cyc(); cyc();
        for (int k = 0; k < 7; k++) begin
            if (k < 3) set_a(1, 0, 6'(k + 1), 0, 0); else idle();
            cyc();
            n_cmp += 2;
            if (aq[0] !== want0[k]) begin n_bad++; $display("FAIL rl1_seq k=%0d got %h want %h", k, aq[0], want0[k]); end
            if (aq[1] !== want1[k]) begin n_bad++; $display("FAIL rl2_seq k=%0d got %h want %h", k, aq[1], want1[k]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            a_en = ($urandom_range(0, 9) < 7); a_wr = $urandom_range(0, 1) == 1;
            a_addr = 6'($urandom_range(0, 63)); a_be = 4'($urandom); a_d = $urandom;
            b_en = ($urandom_range(0, 9) < 7); b_wr = $urandom_range(0, 1) == 1;
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 6'($urandom_range(0, 63));
            b_be = 4'($urandom); b_d = $urandom;
            cyc();
            for (int d = 0; d < 2; d++) begin
                n_cmp += 3;
                if (bsy[d] !== e_busy(d)) begin n_bad++; $display("FAIL rand_busy dut%0d k=%0d got %b want %b", d, k, bsy[d], e_busy(d)); end
                if (aq[d] !== e_aq(d)) begin n_bad++; $display("FAIL rand_aq dut%0d k=%0d got %h want %h", d, k, aq[d], e_aq(d)); end
                if (bq[d] !== e_bq(d)) begin n_bad++; $display("FAIL rand_bq dut%0d k=%0d got %h want %h", d, k, bq[d], e_bq(d)); end
            end
        end
        idle();
    endtask

    // Interrupt a sweep at counter 20; the restarted sweep must run in full.
    task automatic test_mid_reset();
        int done_at [2] = '{0, 0};
        rst = 1'b1; cyc();
        rst = 1'b0;
        repeat (20) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        for (int k = 1; k <= 200 && (done_at[0] == 0 || done_at[1] == 0); k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                if (!bsy[d] && done_at[d] == 0) done_at[d] = k;
                n_cmp += 2;
                if (bsy[d] !== e_busy(d)) begin n_bad++; $display("FAIL mid_busy dut%0d got %b want %b", d, bsy[d], e_busy(d)); end
                if (aq[d] !== 32'h0) begin n_bad++; $display("FAIL mid_aq dut%0d got %h want 0", d, aq[d]); end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (done_at[d] != len_c[d]) begin n_bad++; $display("FAIL mid_len dut%0d got %0d want %0d", d, done_at[d], len_c[d]); end
        end
        for (int a = 0; a < 64; a++) begin
            set_a(1, 0, 6'(a), 0, 0);
            set_b(1, 0, 6'(63 - a), 0, 0);
            cyc();
            idle(); cyc();
            for (int d = 0; d < 2; d++) begin
                logic [31:0] wa = (a < len_c[d]) ? init_c[d] : 32'h0;
                logic [31:0] wb = ((63 - a) < len_c[d]) ? init_c[d] : 32'h0;
                n_cmp += 2;
                if (aq[d] !== wa) begin n_bad++; $display("FAIL mid_word_a dut%0d a=%0d got %h want %h", d, a, aq[d], wa); end
                if (bq[d] !== wb) begin n_bad++; $display("FAIL mid_word_b dut%0d a=%0d got %h want %h", d, 63 - a, bq[d], wb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_write();
        test_rdw();
        test_collision();
        test_rl2();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
